// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Every access is a registered req/ready handshake that gives up after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;
    logic              d_req;
    logic              done;

    assign d_req = MemRead | MemWrite;
    // Ready wins over timeout when both land in the final wait cycle.
    assign done  = mem_ready | (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                end else if (if_req) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    cnt_d      = '0;
                end
            end
            FETCH, DATA: begin
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = ~mem_ready;
                    if (state_q == FETCH) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!mem_ready) begin
                            d_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign err       = err_q;
    assign stall     = (d_req & ~d_valid_q) | (if_req & ~if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder and a completion
// monitor pop expectations produced by a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req, MemRead, MemWrite, mem_ready;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_valid, d_valid, err, mem_req, mem_we, stall;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .MemRead(MemRead), .MemWrite(MemWrite), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata_mem;
        int            delay;
        int            req_cyc;
        int            exp_cyc;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } txn_t;

    txn_t          mem_q[$];
    txn_t          rsp_q[$];
    logic [DW-1:0] d_shadow = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Cycles mem_req stays high: delay counts wait cycles before ready.
    function automatic int ncyc(input int dly);
        return (dly < TO) ? dly + 1 : TO;
    endfunction

    // Memory responder: checks each access and answers after its delay.
    initial begin : responder
        txn_t cur;
        bit   have;
        bit   req_s;
        int   wc;
        have      = 0;
        wc        = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            req_s = mem_req;
            if (!reset_n) begin
                have = 0;
                wc   = 0;
                #1;
                mem_ready = 1'b0;
            end else if (req_s) begin
                if (!have) begin
                    if (mem_q.size() == 0) begin
                        fail_now("unexpected_mem_req");
                    end else begin
                        cur  = mem_q.pop_front();
                        have = 1;
                        wc   = 0;
                        check("grant_cycle", cyc, cur.req_cyc);
                    end
                end
                if (have) begin
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_we", mem_we, cur.we);
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
                #1;
                if (have && wc == cur.delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.rdata_mem;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                wc++;
            end else begin
                if (have) begin
                    check("mem_req_cycles", wc, ncyc(cur.delay));
                    have = 0;
                end
                #1;
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Completion monitor: stall rule every cycle, scoreboard on valid pulses.
    initial begin : monitor
        txn_t t;
        logic exp_stall;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                exp_stall = ((MemRead | MemWrite) & ~d_valid) | (if_req & ~if_valid);
                check("stall", stall, exp_stall);
                if (if_valid && d_valid) begin
                    fail_now("both_valid");
                end else if (if_valid || d_valid) begin
                    if (rsp_q.size() == 0) begin
                        fail_now("unexpected_valid");
                    end else begin
                        t = rsp_q.pop_front();
                        check("valid_side_d", d_valid, t.is_d);
                        check("valid_cycle", cyc, t.exp_cyc);
                        check("err", err, t.exp_err);
                        if (t.is_d) check("d_rdata", d_rdata, t.exp_rdata);
                        else        check("if_rdata", if_rdata, t.exp_rdata);
                    end
                end else if (err) begin
                    fail_now("err_without_valid");
                end
            end
        end
    end

    // Issues a data and/or fetch request from IDLE and holds each until its valid.
    task automatic run_txn(input bit do_d, input bit do_f, input bit rd, input bit wr,
                           input int dly_d, input int dly_f, input bit withdraw,
                           input logic [AW-1:0] da, input logic [DW-1:0] dw,
                           input logic [DW-1:0] drd, input logic [AW-1:0] fa,
                           input logic [DW-1:0] frd);
        txn_t t;
        int   r, d_end, f_req;
        bit   d_done, f_done;
        r     = cyc;
        d_end = r;
        if (do_d) begin
            t.is_d = 1; t.we = wr; t.addr = da; t.wdata = dw; t.rdata_mem = drd;
            t.delay = dly_d; t.req_cyc = r + 1; t.exp_cyc = r + 1 + ncyc(dly_d);
            t.exp_err = (dly_d >= TO);
            t.exp_rdata = t.exp_err ? '0 : (wr ? d_shadow : drd);
            d_shadow = t.exp_rdata;
            d_end = t.exp_cyc;
            mem_q.push_back(t);
            rsp_q.push_back(t);
        end
        f_req = do_d ? d_end + 2 : r + 1;
        if (do_f) begin
            t.is_d = 0; t.we = 0; t.addr = fa; t.wdata = '0; t.rdata_mem = frd;
            t.delay = dly_f; t.req_cyc = f_req; t.exp_cyc = f_req + ncyc(dly_f);
            t.exp_err = (dly_f >= TO);
            t.exp_rdata = t.exp_err ? '0 : frd;
            mem_q.push_back(t);
            rsp_q.push_back(t);
        end
        MemRead  = do_d & rd;
        MemWrite = do_d & wr;
        d_addr   = da;
        d_wdata  = dw;
        if_req   = do_f;
        if_addr  = fa;
        d_done   = !do_d;
        f_done   = !do_f;
        for (int n = 0; n < 200 && !(d_done && f_done); n++) begin
            @(negedge clk);
            if (d_valid) d_done = 1;
            if (if_valid) f_done = 1;
            #1;
            if (do_d && cyc == r + 1) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
                if (withdraw) begin
                    MemRead  = 1'b0;
                    MemWrite = 1'b0;
                end
            end
            if (do_f && cyc == f_req) if_addr = $urandom;
            if (d_done) begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
            if (f_done) if_req = 1'b0;
        end
        if (!(d_done && f_done)) fail_now("txn_completion_timeout");
        @(negedge clk);
        #1;
    endtask

    task automatic reset_mid_data();
        txn_t t;
        int   r;
        r = cyc;
        t.is_d = 1; t.we = 0; t.addr = 32'h0000_0200; t.wdata = '0; t.rdata_mem = 32'h1234_5678;
        t.delay = 50; t.req_cyc = r + 1; t.exp_cyc = 0; t.exp_err = 0; t.exp_rdata = '0;
        mem_q.push_back(t);
        MemRead = 1'b1;
        d_addr  = t.addr;
        @(negedge clk);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_err", err, 0);
        MemRead  = 1'b0;
        d_shadow = '0;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin : stimulus
        int   kind, op, dd, df;
        bit   rd, wr;
        reset_n  = 1'b0;
        if_req   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if_addr  = '0;
        d_addr   = '0;
        d_wdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_mem_req", mem_req, 0);
        check("reset_if_valid", if_valid, 0);
        check("reset_d_valid", d_valid, 0);
        check("reset_err", err, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_if_rdata", if_rdata, 0);
        check("reset_d_rdata", d_rdata, 0);
        check("reset_stall", stall, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        run_txn(0, 1, 0, 0, 0, 0, 0, '0, '0, '0, 32'h10, 32'h0050_0093);
        run_txn(1, 0, 0, 1, 2, 0, 0, 32'h100, 32'hDEAD_BEEF, 32'h5555_AAAA, '0, '0);
        run_txn(1, 1, 1, 0, 0, 0, 0, 32'h104, '0, 32'h11, 32'h14, 32'h22);
        run_txn(0, 1, 0, 0, 99, 99, 0, '0, '0, '0, 32'h18, 32'hFFFF_FFFF);
        run_txn(0, 1, 0, 0, TO - 1, TO - 1, 0, '0, '0, '0, 32'h1C, 32'h0BAD_F00D);
        reset_mid_data();
        run_txn(1, 0, 1, 0, 2, 0, 1, 32'h300, '0, 32'hA5, '0, '0);
        run_txn(1, 0, 1, 1, 1, 0, 0, 32'h304, 32'hCAFE_0001, 32'h77, '0, '0);
        run_txn(1, 0, 1, 0, TO, 0, 0, 32'h308, '0, 32'h99, '0, '0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            op   = $urandom_range(0, 2);
            rd   = (op != 1);
            wr   = (op != 0);
            dd   = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 4);
            df   = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 4);
            run_txn(kind != 0, kind == 0 || kind == 2, rd, wr, dd, df, kind == 3,
                    $urandom, $urandom, $urandom, $urandom, $urandom);
        end

        repeat (4) @(negedge clk);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch and the load/store path of the processor.
- The load/store path is driven by the MemRead/MemWrite decodes from the control unit.
- Sequences each access as a registered request/ready transaction with a timeout, and returns read data and completion pulses to each side.
- Produces a stall that freezes the PC and register-file write until every outstanding access of the current instruction has completed.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT, 15, number of granted cycles without mem_ready before the transaction is aborted with an error (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, level; held until if_valid.
- if_addr  in  ADDR_W  fetch address (the PC).
- if_rdata  out  DATA_W  fetched instruction, registered.
- if_valid  out  1  one-cycle fetch completion pulse.
- MemRead  in  1  load request from the control unit, level.
- MemWrite  in  1  store request from the control unit, level.
- d_addr  in  ADDR_W  load/store address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- d_valid  out  1  one-cycle load/store completion pulse.
- err  out  1  one-cycle pulse coincident with a valid pulse when the transaction timed out.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- stall  out  1  combinational processor stall.

Behaviour:
- States: IDLE, FETCH, DATA, RESP.
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; the timeout counter clears.
  - All registered outputs clear to 0, with mem_req dropping immediately.
  - Any in-flight transaction is abandoned and no valid pulse is produced.
- Define d_req = MemRead | MemWrite.
- IDLE arbitration:
  - d_req=1 → DATA. d_req has fixed priority over if_req.
  - else if_req=1 → FETCH.
  - else remain in IDLE.
- Grant (the IDLE→FETCH/DATA edge):
  - Capture mem_addr from d_addr or if_addr.
  - Capture mem_wdata from d_wdata on a data grant.
  - Set mem_we = MemWrite on a data grant, 0 on a fetch grant.
  - Set mem_req=1.
  - Clear the counter.
- Address/data stability: mem_addr, mem_wdata and mem_we stay stable while mem_req=1. Input changes after grant are ignored.
- If MemRead and MemWrite are both high, the access is a write.
- FETCH/DATA, mem_ready=1:
  - Go to RESP and drop mem_req.
  - On a read, load mem_rdata into if_rdata or d_rdata.
  - On a write, d_rdata holds its previous value.
- FETCH/DATA, mem_ready=0:
  - Increment the counter.
  - When the counter reaches TIMEOUT-1 with no ready, go to RESP with the error flag set, load 0 into the target rdata, and drop mem_req.
- RESP:
  - Lasts exactly one cycle.
  - Asserts if_valid or d_valid for the completed side, plus err if the transaction timed out.
  - No grant is made in RESP; next state is always IDLE.
  - This gives requesters one cycle to drop or change their level request.
- Latency: request high in IDLE at cycle N → mem_req at N+1. With mem_ready at N+1, valid is high at N+2 and the next grant is possible at N+3.
- Request withdrawn mid-transaction: the transaction still completes and the valid pulse is still issued.
- Stall: stall = (d_req & ~d_valid) | (if_req & ~if_valid).
- Instruction ordering: a fetch and a data request pending together are served data first, then fetch. stall stays high until the last of them pulses valid.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset, then if_req=1 with if_addr=0x00000010 and memory ready on first mem_req cycle returning 0x00500093 → mem_req high cycle 1 with mem_addr=0x10 and mem_we=0; if_valid=1 and if_rdata=0x00500093 at cycle 2; stall=1 at cycles 0-1 and 0 at cycle 2.
- MemWrite=1, d_addr=0x100, d_wdata=0xDEADBEEF with 3-cycle ready delay → mem_we=1 and mem_wdata=0xDEADBEEF held stable for 3 cycles; d_valid pulses once; d_rdata unchanged.
- if_req and MemRead both high in IDLE, memory returning 0x11 (data) then 0x22 (fetch) → DATA served first with d_rdata=0x11; RESP, IDLE, FETCH follow with if_rdata=0x22; stall falls only on the if_valid cycle.
- Fetch with mem_ready never asserted, TIMEOUT=15 → mem_req high for exactly 15 cycles; if_valid and err pulse together; if_rdata=0.
- reset_n pulled low mid-DATA on the second wait cycle → mem_req and all outputs go to 0 asynchronously before the next edge; after release, no d_valid for the aborted access; a new request is granted normally.
- MemRead dropped one cycle after grant, mem_ready after 2 cycles with 0xA5 → d_valid still pulses with d_rdata=0xA5; mem_ready asserted while in IDLE causes no state change.
